// File: rtl/reg_rr_arbiter_pkg.sv
// Shared types and defaults for the register-interface round-robin arbiter.
// Carries the register bus structs, the FSM encoding and the system-level constants.
package reg_rr_arbiter_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  // System defaults: number of register masters and the hung-slave watchdog limit.
  localparam int unsigned NumRegMasters = 2;
  localparam int unsigned RegArbTimeout = 1024;

  typedef struct packed {
    logic                 valid;
    logic                 write;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] wstrb;
  } reg_req_t;

  typedef struct packed {
    logic                 ready;
    logic [DataWidth-1:0] rdata;
    logic                 error;
  } reg_resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_rr_arbiter_rr_pick.sv
// Combinational round-robin first-one search: scans valid starting at ptr,
// wrapping modulo NumReq, and returns the first set index.
module reg_rr_arbiter_rr_pick #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = 1
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   ptr,
  output logic [IdxW-1:0]   idx,
  output logic              any_valid
);

  always_comb begin
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    // NOTE: every combinational output gets a default before any branch, so no
    // path through the block leaves it unassigned and no latch is inferred.
    idx       = '0;
    any_valid = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand     = (32'(ptr) + i) % NumReq;
      cand_idx = IdxW'(cand);
      if (!any_valid && valid[cand_idx]) begin
        any_valid = 1'b1;
        idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter sharing one register-interface slave between NumReq
// requesters, one transaction in flight, with a watchdog for hung slaves.
module reg_rr_arbiter
  import reg_rr_arbiter_pkg::*;
#(
  parameter  int unsigned NumReq        = NumRegMasters,
  parameter  int unsigned TimeoutCycles = RegArbTimeout,
  parameter  int unsigned CntWidth      = 16,
  localparam int unsigned IdxW          = idx_width(NumReq)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  reg_req_t        req_i  [NumReq],
  output reg_resp_t       resp_o [NumReq],
  output reg_req_t        req_o,
  input  reg_resp_t       resp_i,
  output logic            busy_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            timeout_o
);

  localparam logic [CntWidth-1:0] WdLimit =
    (TimeoutCycles == 0) ? '0 : CntWidth'(TimeoutCycles - 1);
  localparam bit WdEnable = (TimeoutCycles != 0);

  arb_state_e          state_q;
  logic [IdxW-1:0]     rr_ptr_q;
  logic [IdxW-1:0]     gnt_idx_q;
  logic [CntWidth-1:0] cnt_q;

  logic [NumReq-1:0]   valid_vec;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_any;
  logic [IdxW-1:0]     next_ptr;

  reg_req_t            gnt_req;
  logic                in_busy;
  logic                wd_expired;
  logic                fire_drop;
  logic                fire_ready;
  logic                fire_timeout;

  always_comb begin
    for (int unsigned k = 0; k < NumReq; k++) begin
      valid_vec[k] = req_i[k].valid;
    end
  end

  reg_rr_arbiter_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .valid     (valid_vec),
    .ptr       (rr_ptr_q),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  assign next_ptr = (gnt_idx_q == IdxW'(NumReq - 1)) ? '0 : gnt_idx_q + 1'b1;

  // BUSY-cycle event decode; a withdrawn request outranks ready, ready outranks the watchdog.
  always_comb begin
    gnt_req      = req_i[gnt_idx_q];
    in_busy      = (state_q == BUSY);
    wd_expired   = WdEnable && (cnt_q == WdLimit);
    fire_drop    = in_busy && !gnt_req.valid;
    fire_ready   = in_busy && gnt_req.valid && resp_i.ready;
    fire_timeout = in_busy && gnt_req.valid && !resp_i.ready && wd_expired;
  end

  always_comb begin
    req_o = '0;
    if (in_busy) begin
      req_o       = gnt_req;
      req_o.valid = gnt_req.valid && !fire_timeout;
    end
  end

  // Only the granted port ever sees a response; all others stay zero.
  always_comb begin
    for (int unsigned k = 0; k < NumReq; k++) begin
      resp_o[k] = '0;
    end
    if (fire_ready) begin
      resp_o[gnt_idx_q] = resp_i;
    end else if (fire_timeout) begin
      resp_o[gnt_idx_q].ready = 1'b1;
      resp_o[gnt_idx_q].error = 1'b1;
      resp_o[gnt_idx_q].rdata = '0;
    end
  end

  assign busy_o    = in_busy;
  assign gnt_idx_o = gnt_idx_q;
  assign timeout_o = fire_timeout;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_idx_q <= pick_idx;
            cnt_q     <= '0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (fire_drop) begin
            state_q <= IDLE;
          end else if (fire_ready || fire_timeout) begin
            rr_ptr_q <= next_ptr;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Directed bench for reg_rr_arbiter: two requesters, watchdog limit of 8 cycles.
// Inputs change and outputs are sampled just after the falling edge.
module tb_reg_rr_arbiter;
  import reg_rr_arbiter_pkg::*;

  localparam int unsigned N = 2;

  logic      clk   = 1'b0;
  logic      rst_n = 1'b0;
  reg_req_t  req   [N];
  reg_resp_t resp  [N];
  reg_req_t  sreq;
  reg_resp_t sresp;
  logic      busy;
  logic      tmo;
  logic [0:0] gnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_rr_arbiter #(
    .NumReq        (N),
    .TimeoutCycles (8),
    .CntWidth      (16)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .resp_o    (resp),
    .req_o     (sreq),
    .resp_i    (sresp),
    .busy_o    (busy),
    .gnt_idx_o (gnt),
    .timeout_o (tmo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic reg_req_t mk(input logic w, input logic [31:0] a, input logic [31:0] d);
    reg_req_t r;
    r.valid = 1'b1;
    r.write = w;
    r.addr  = a;
    r.wdata = d;
    r.wstrb = 4'hF;
    return r;
  endfunction

  function automatic reg_resp_t rsp(input logic [31:0] d, input logic e);
    reg_resp_t r;
    r.ready = 1'b1;
    r.rdata = d;
    r.error = e;
    return r;
  endfunction

  task automatic idle_inputs();
    for (int k = 0; k < N; k++) req[k] = '0;
    sresp = '0;
  endtask

  initial begin
    int          g;
    logic [31:0] exp_addr;

    idle_inputs();

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_tmo", 32'(tmo), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_req_valid", 32'(sreq.valid), 0);
    check("rst_req_addr", sreq.addr, 0);
    check("rst_resp0_ready", 32'(resp[0].ready), 0);
    check("rst_resp1_ready", 32'(resp[1].ready), 0);
    rst_n = 1'b1;

    // Single read on port 0, slave ready in the third BUSY cycle
    @(negedge clk);
    req[0] = mk(1'b0, 32'h10, 32'h0);
    #1;
    check("t1_idle_valid", 32'(sreq.valid), 0);
    check("t1_idle_busy", 32'(busy), 0);
    @(negedge clk); #1;
    check("t1_req_valid", 32'(sreq.valid), 1);
    check("t1_req_addr", sreq.addr, 32'h10);
    check("t1_gnt", 32'(gnt), 0);
    check("t1_early_ready", 32'(resp[0].ready), 0);
    @(negedge clk); #1;
    check("t1_wait_ready", 32'(resp[0].ready), 0);
    @(negedge clk);
    sresp = rsp(32'hA5, 1'b0);
    #1;
    check("t1_resp0_ready", 32'(resp[0].ready), 1);
    check("t1_resp0_rdata", resp[0].rdata, 32'hA5);
    check("t1_resp1_ready", 32'(resp[1].ready), 0);
    check("t1_resp1_rdata", resp[1].rdata, 0);
    check("t1_tmo", 32'(tmo), 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t1_back_idle", 32'(busy), 0);
    check("t1_gnt_hold", 32'(gnt), 0);

    // Reset so the pointer restarts at 0
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Both ports requesting continuously: grants 0,1,0,1 with an IDLE cycle between
    @(negedge clk);
    req[0] = mk(1'b0, 32'h100, 32'h0);
    req[1] = mk(1'b0, 32'h200, 32'h0);
    #1;
    check("t2_start_idle", 32'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      g        = i % 2;
      exp_addr = (g == 1) ? 32'h200 : 32'h100;
      @(negedge clk); #1;
      check("t2_busy", 32'(busy), 1);
      check("t2_gnt", 32'(gnt), 32'(g));
      check("t2_addr", sreq.addr, exp_addr);
      sresp = rsp(32'h1000 + 32'(i), 1'b0);
      #1;
      check("t2_resp_ready", 32'(resp[g].ready), 1);
      check("t2_resp_rdata", resp[g].rdata, 32'h1000 + 32'(i));
      check("t2_other_ready", 32'(resp[1-g].ready), 0);
      @(negedge clk);
      sresp = '0;
      if (i == 3) begin
        req[0].valid = 1'b0;
        req[1].valid = 1'b0;
      end
      #1;
      check("t2_gap_idle", 32'(busy), 0);
      check("t2_gap_valid", 32'(sreq.valid), 0);
      check("t2_gnt_hold", 32'(gnt), 32'(g));
    end

    // Watchdog: slave never ready, fires in the 8th BUSY cycle
    @(negedge clk);
    req[0] = mk(1'b0, 32'h30, 32'h0);
    #1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      sresp       = '0;
      sresp.rdata = 32'hBAD0_0000;
      #1;
      check("t3_no_tmo", 32'(tmo), 0);
      check("t3_no_ready", 32'(resp[0].ready), 0);
    end
    @(negedge clk); #1;
    check("t3_tmo", 32'(tmo), 1);
    check("t3_ready", 32'(resp[0].ready), 1);
    check("t3_error", 32'(resp[0].error), 1);
    check("t3_rdata", resp[0].rdata, 0);
    check("t3_req_valid", 32'(sreq.valid), 0);
    check("t3_other_ready", 32'(resp[1].ready), 0);
    @(negedge clk);
    req[0].valid = 1'b0;
    sresp        = rsp(32'h77, 1'b0);
    #1;
    check("t3_late_ready0", 32'(resp[0].ready), 0);
    check("t3_late_ready1", 32'(resp[1].ready), 0);
    check("t3_late_tmo", 32'(tmo), 0);
    check("t3_late_idle", 32'(busy), 0);

    // Write on port 1 answered with a slave error
    @(negedge clk);
    sresp  = '0;
    req[1] = mk(1'b1, 32'h20, 32'hDEAD_BEEF);
    #1;
    @(negedge clk); #1;
    check("t4_gnt", 32'(gnt), 1);
    check("t4_write", 32'(sreq.write), 1);
    check("t4_wdata", sreq.wdata, 32'hDEAD_BEEF);
    check("t4_wstrb", 32'(sreq.wstrb), 32'hF);
    sresp = rsp(32'h0, 1'b1);
    #1;
    check("t4_ready", 32'(resp[1].ready), 1);
    check("t4_error", 32'(resp[1].error), 1);
    check("t4_tmo", 32'(tmo), 0);
    check("t4_other_ready", 32'(resp[0].ready), 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t4_idle", 32'(busy), 0);

    // Granted requester withdraws: no response, pointer stays at 0
    @(negedge clk);
    req[0] = mk(1'b0, 32'h40, 32'h0);
    #1;
    @(negedge clk); #1;
    check("t5_gnt", 32'(gnt), 0);
    check("t5_valid", 32'(sreq.valid), 1);
    @(negedge clk);
    req[0].valid = 1'b0;
    #1;
    check("t5_drop_valid", 32'(sreq.valid), 0);
    check("t5_drop_ready", 32'(resp[0].ready), 0);
    check("t5_drop_busy", 32'(busy), 1);
    @(negedge clk);
    req[0] = mk(1'b0, 32'h44, 32'h0);
    req[1] = mk(1'b0, 32'h48, 32'h0);
    #1;
    check("t5_idle", 32'(busy), 0);
    @(negedge clk); #1;
    check("t5_ptr_kept", 32'(gnt), 0);
    check("t5_addr", sreq.addr, 32'h44);
    sresp = rsp(32'h44, 1'b0);
    #1;
    check("t5_ready", 32'(resp[0].ready), 1);
    @(negedge clk);
    idle_inputs();

    // Reset mid-BUSY on port 1, then port 1 alone after release
    @(negedge clk);
    req[1] = mk(1'b0, 32'h50, 32'h0);
    #1;
    @(negedge clk); #1;
    check("t6_busy", 32'(busy), 1);
    check("t6_gnt", 32'(gnt), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_valid", 32'(sreq.valid), 0);
    check("t6_rst_gnt", 32'(gnt), 0);
    check("t6_rst_ready", 32'(resp[1].ready), 0);
    check("t6_rst_tmo", 32'(tmo), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("t6_post_busy", 32'(busy), 1);
    check("t6_post_gnt", 32'(gnt), 1);
    sresp = rsp(32'h5A, 1'b0);
    #1;
    check("t6_post_rdata", resp[1].rdata, 32'h5A);
    check("t6_post_other", 32'(resp[0].ready), 0);
    @(negedge clk);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
